// File: rtl/uart_rx_fifo.sv
// Purpose: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through byte FIFO.
// Latency: rx_valid rises 1 clk after the stop-bit sample; the line passes through a 2-flop synchroniser first.
// Backpressure: none on the line; a byte arriving while the FIFO is full is dropped and sets sticky overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int BW   = $clog2(CPB);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            rx_meta;
    logic            rx_s;
    logic            par_bad;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            stop_tick;
    logic            push;
    logic            err_set;
    logic            full;
    logic            pop;
    logic            wr_ok;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: half-bit start check, 8 LSB-first data samples, optional parity, stop check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad  <= 1'b0;
`endif
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rx_s, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        par_bad  <= (rx_s != ^shift);
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_BREAK: begin
                    baud_cnt <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    // The stop-bit sample decides push versus error in the same cycle.
    assign stop_tick = (state == S_STOP) && (baud_cnt == BAUD_LAST);
    assign push      = stop_tick && rx_s && !par_bad;
    assign err_set   = stop_tick && (!rx_s || par_bad);

    assign full  = (count == CNT_FULL);
    assign pop   = rd_en && (count != '0);
    assign wr_ok = push && (!full || pop);

    // Pointers wrap naturally; the separate count removes full/empty ambiguity.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem[wr_ptr] <= shift;
    end

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !pop) overrun <= 1'b1;
            else if (clr_err)         overrun <= 1'b0;
            if (err_set)              frame_err <= 1'b1;
            else if (clr_err)         frame_err <= 1'b0;
        end
    end

    assign rd_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign rx_valid = (count != '0);
    assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed bench for uart_rx_fifo at 10 clk/bit with a 4-entry FIFO.
// Latency: frames are driven bit by bit on the falling edge; outputs are sampled on the falling edge.
// Backpressure: reads are issued by the bench with rd_en pulses.
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 4;
    localparam int CPB    = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_count;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d;
        idle(CPB);
`endif
        rx = stop;
        idle(CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic pbit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = pbit;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
    endtask
`endif

    task automatic pop_one();
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd1, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[4] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 3'd1, 1'b0};

        reset   = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(2);
        check("reset rd_data",   rd_data,   0);
        check("reset rx_valid",  rx_valid,  0);
        check("reset rx_count",  rx_count,  0);
        check("reset overrun",   overrun,   0);
        check("reset frame_err", frame_err, 0);

        // First frame: measure start-edge to rx_valid latency.
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!rx_valid && lat < 200) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("A5 latency in 95..100", (lat >= 95 && lat <= 100), 1);
        check("A5 rd_data",  rd_data,  8'hA5);
        check("A5 rx_count", rx_count, 1);
        pop_one();
        check("A5 pop rx_valid", rx_valid, 0);
        check("A5 pop rx_count", rx_count, 0);

        // Read on empty is ignored.
        pop_one();
        check("empty rd rx_count", rx_count, 0);
        check("empty rd rd_data",  rd_data,  0);
        check("empty rd overrun",  overrun,  0);

        // Short low glitch on idle line.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        check("glitch rx_valid",  rx_valid,  0);
        check("glitch frame_err", frame_err, 0);
        check("glitch overrun",   overrun,   0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) idle(30);
            rx = 1'b1;
            idle(20);
            check($sformatf("vec%0d rx_valid", i),  rx_valid,  vecs[i].exp_valid);
            check($sformatf("vec%0d rd_data", i),   rd_data,   vecs[i].exp_data);
            check($sformatf("vec%0d rx_count", i),  rx_count,  vecs[i].exp_count);
            check($sformatf("vec%0d frame_err", i), frame_err, vecs[i].exp_ferr);
            if (vecs[i].exp_valid) pop_one();
            clear_errs();
            check($sformatf("vec%0d cleared", i), {rx_count, frame_err}, 0);
        end

        // Overrun: five bytes into a four-deep FIFO.
        for (int d = 1; d <= 5; d++) begin
            send_byte(8'(d), 1'b1);
            idle(2);
        end
        check("ovr rx_count",  rx_count,  4);
        check("ovr overrun",   overrun,   1);
        check("ovr frame_err", frame_err, 0);
        for (int d = 1; d <= 4; d++) begin
            check($sformatf("ovr pop%0d", d), rd_data, d);
            pop_one();
        end
        check("ovr drained", rx_count, 0);
        clear_errs();
        check("ovr cleared", overrun, 0);

        // Full FIFO, push and pop in the same cycle.
        for (int d = 1; d <= 4; d++) begin
            send_byte(8'(d), 1'b1);
            idle(2);
        end
        fork
            send_byte(8'h99, 1'b1);
            begin
                idle(97);
                check("fullpp pre count", rx_count, 4);
                check("fullpp pre head",  rd_data,  8'h01);
                rd_en = 1'b1;
                idle(1);
                rd_en = 1'b0;
            end
        join
        check("fullpp count",   rx_count, 4);
        check("fullpp overrun", overrun,  0);
        check("fullpp head",    rd_data,  8'h02);
        check("fullpp pop2", rd_data, 8'h02); pop_one();
        check("fullpp pop3", rd_data, 8'h03); pop_one();
        check("fullpp pop4", rd_data, 8'h04); pop_one();
        check("fullpp pop99", rd_data, 8'h99); pop_one();
        check("fullpp drained", rx_count, 0);

        // Reset during bit 4 of 0xFF with one byte already buffered.
        send_byte(8'h11, 1'b1);
        idle(5);
        check("rst pre count", rx_count, 1);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB * 4 + 5);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        check("rst rd_data",   rd_data,   0);
        check("rst rx_valid",  rx_valid,  0);
        check("rst rx_count",  rx_count,  0);
        check("rst overrun",   overrun,   0);
        check("rst frame_err", frame_err, 0);
        idle(CPB * 6);
        check("rst no partial push", rx_count, 0);
        send_byte(8'h55, 1'b1);
        idle(5);
        check("post rst rd_data",   rd_data,   8'h55);
        check("post rst rx_count",  rx_count,  1);
        check("post rst frame_err", frame_err, 0);
        pop_one();

`ifdef UART_RX_PARITY_EN
        send_par(8'h03, 1'b0);
        idle(5);
        check("par ok rd_data",   rd_data,   8'h03);
        check("par ok rx_count",  rx_count,  1);
        check("par ok frame_err", frame_err, 0);
        pop_one();
        send_par(8'h03, 1'b1);
        idle(5);
        check("par bad rx_count",  rx_count,  0);
        check("par bad frame_err", frame_err, 1);
        clear_errs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
